// File: rtl/vga_pattern_gen.sv
// Pixel-colour stage: turns VGA timing (sync, DE, x/y) into 12-bit RGB test patterns.
// Two-cycle pipeline; the pattern select is latched only at the start of each frame.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned BAR_STEP      = 1,
  parameter bit          VS_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic [2:0]  sw_i,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic        de_i,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  output logic        hs_o,
  output logic        vs_o,
  output logic        de_o,
  output logic [11:0] rgb_o
);

  localparam int unsigned BarW     = H_ACTIVE / 8;
  localparam logic [9:0]  SegLast  = 10'(BarW - 1);
  localparam logic        SyncIdle = VS_ACTIVE_LOW;

  if (H_ACTIVE > 1024 || V_ACTIVE > 1024) begin : g_range_check
    $error("vga_pattern_gen: active area exceeds 10-bit coordinates");
  end

  logic [2:0]  mode_q, mode_d;
  logic [9:0]  pos_q, pos_d;
  logic [3:0]  frame_q, frame_d;
  logic [2:0]  idx_q, idx_d;
  logic [9:0]  seg_q, seg_d;
  logic        vs_prev_q;
  logic [11:0] col_q, col_d;
  logic        hs1_q, vs1_q, de1_q;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, vs2_q, de2_q;

  logic        fb;
  logic [31:0] pos_sum;
  logic        in_bar;
  logic        unused_y;

  assign unused_y = ^{y_i[9], y_i[4:0]};

  // Frame boundary: vsync moving into its asserted level.
  assign fb = (vs_i != SyncIdle) && (vs_prev_q == SyncIdle);

  assign in_bar = ({1'b0, x_i} >= {1'b0, pos_q}) && ({1'b0, x_i} < ({1'b0, pos_q} + 11'd16));

  always_comb begin
    mode_d  = mode_q;
    pos_d   = pos_q;
    frame_d = frame_q;
    pos_sum = 32'(pos_q) + BAR_STEP;
    if (fb) begin
      mode_d  = sw_i;
      pos_d   = (pos_sum >= H_ACTIVE) ? 10'd0 : pos_sum[9:0];
      frame_d = frame_q + 4'd1;
    end

    // Bar index follows pixel count within the DE run, not x_i.
    idx_d = idx_q;
    seg_d = seg_q;
    if (!de_i) begin
      idx_d = '0;
      seg_d = '0;
    end else if (seg_q == SegLast) begin
      seg_d = '0;
      if (idx_q != 3'd7) idx_d = idx_q + 3'd1;
    end else begin
      seg_d = seg_q + 10'd1;
    end

    col_d = 12'h000;
    if (mode_q[2]) begin
      unique case (mode_q[1:0])
        2'b00: begin
          unique case (idx_q)
            3'd0:    col_d = 12'hFFF;
            3'd1:    col_d = 12'hFF0;
            3'd2:    col_d = 12'h0FF;
            3'd3:    col_d = 12'h0F0;
            3'd4:    col_d = 12'hF0F;
            3'd5:    col_d = 12'hF00;
            3'd6:    col_d = 12'h00F;
            default: col_d = 12'h000;
          endcase
        end
        2'b01:   col_d = (x_i[5] ^ y_i[5]) ? 12'h000 : 12'hFFF;
        2'b10:   col_d = in_bar ? 12'hFFF : 12'h000;
        default: col_d = {x_i[9:6], y_i[8:5], frame_q};
      endcase
    end

    rgb_d = de1_q ? col_q : 12'h000;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      mode_q    <= '0;
      pos_q     <= '0;
      frame_q   <= '0;
      idx_q     <= '0;
      seg_q     <= '0;
      vs_prev_q <= SyncIdle;
      col_q     <= '0;
      hs1_q     <= SyncIdle;
      vs1_q     <= SyncIdle;
      de1_q     <= 1'b0;
      rgb_q     <= '0;
      hs2_q     <= SyncIdle;
      vs2_q     <= SyncIdle;
      de2_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pos_q     <= pos_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      vs_prev_q <= vs_i;
      col_q     <= col_d;
      hs1_q     <= hs_i;
      vs1_q     <= vs_i;
      de1_q     <= de_i;
      rgb_q     <= rgb_d;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      de2_q     <= de1_q;
    end
  end

  assign hs_o  = hs2_q;
  assign vs_o  = vs2_q;
  assign de_o  = de2_q;
  assign rgb_o = rgb_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: randomised frames/lines against a behavioural pixel model,
// expected outputs queued at drive time and compared by a separate monitor.
module tb_vga_pattern_gen;

  localparam int HA   = 640;
  localparam int STEP = 320;
  localparam int BW   = HA / 8;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [2:0]  sw_i;
  logic        hs_i, vs_i, de_i;
  logic [9:0]  x_i, y_i;
  logic        hs_o, vs_o, de_o;
  logic [11:0] rgb_o;

  vga_pattern_gen #(
    .H_ACTIVE      (HA),
    .V_ACTIVE      (480),
    .BAR_STEP      (STEP),
    .VS_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .sw_i   (sw_i),
    .hs_i   (hs_i),
    .vs_i   (vs_i),
    .de_i   (de_i),
    .x_i    (x_i),
    .y_i    (y_i),
    .hs_o   (hs_o),
    .vs_o   (vs_o),
    .de_o   (de_o),
    .rgb_o  (rgb_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int   m_mode, m_pos, m_fcnt, m_run;
  logic m_prev_vs;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, tag, act, req);
    end
  endtask

  function automatic logic [11:0] bar_colour(input int i);
    case (i)
      0:       return 12'hFFF;
      1:       return 12'hFF0;
      2:       return 12'h0FF;
      3:       return 12'h0F0;
      4:       return 12'hF0F;
      5:       return 12'hF00;
      6:       return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] pattern(input int mode, input int x, input int y,
                                          input int run, input int pos, input int fcnt);
    int idx;
    if (mode < 4) return 12'h000;
    case (mode % 4)
      0: begin
        idx = run / BW;
        if (idx > 7) idx = 7;
        return bar_colour(idx);
      end
      1:       return (((x / 32) % 2) == ((y / 32) % 2)) ? 12'hFFF : 12'h000;
      2:       return (x >= pos && x < pos + 16) ? 12'hFFF : 12'h000;
      default: return 12'(((x / 64) % 16) * 256 + ((y / 32) % 16) * 16 + fcnt);
    endcase
  endfunction

  task automatic push_exp(input logic hs, input logic vs, input logic de, input logic [11:0] rgb);
    exp_t e;
    e.due = cyc + 2;
    e.hs  = hs;
    e.vs  = vs;
    e.de  = de;
    e.rgb = rgb;
    sb.push_back(e);
  endtask

  // One pixel clock of stimulus; model advances with the same inputs.
  task automatic drive(input logic hs, input logic vs, input logic de, input int x, input int y);
    hs_i = hs;
    vs_i = vs;
    de_i = de;
    x_i  = 10'(x);
    y_i  = 10'(y);
    push_exp(hs, vs, de, de ? pattern(m_mode, x, y, m_run, m_pos, m_fcnt) : 12'h000);
    if (de) m_run++;
    else m_run = 0;
    if (vs == 1'b0 && m_prev_vs == 1'b1) begin
      m_mode = int'(sw_i);
      m_pos  = (m_pos + STEP >= HA) ? 0 : m_pos + STEP;
      m_fcnt = (m_fcnt + 1) % 16;
    end
    m_prev_vs = vs;
    @(posedge clk_i);
    #1;
  endtask

  task automatic line(input int len, input int y);
    repeat (3) drive(1'b0, 1'b1, 1'b0, 0, y);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 0, y);
    for (int x = 0; x < len; x++) drive(1'b1, 1'b1, 1'b1, x, y);
    repeat (2) drive(1'b1, 1'b1, 1'b0, 0, y);
  endtask

  task automatic frame(input logic [2:0] sw, input int nlines, input int y0, input bit trunc);
    int len;
    sw_i = sw;
    repeat (2) drive(1'b1, 1'b0, 1'b0, 0, 0);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 0, 0);
    for (int k = 0; k < nlines; k++) begin
      len = (trunc && $urandom_range(0, 2) == 0) ? $urandom_range(1, HA - 1) : HA;
      line(len, (k == 0) ? y0 : $urandom_range(0, 479));
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic reset_pulse(input int ncyc);
    #2;
    arst_i = 1'b1;
    hs_i   = 1'b1;
    vs_i   = 1'b1;
    de_i   = 1'b0;
    sb.delete();
    #1;
    check("rst_rgb", cyc, 32'(rgb_o), 32'h0);
    check("rst_de", cyc, 32'(de_o), 32'h0);
    check("rst_hs", cyc, 32'(hs_o), 32'h1);
    check("rst_vs", cyc, 32'(vs_o), 32'h1);
    m_mode = 0;
    m_pos = 0;
    m_fcnt = 0;
    m_run = 0;
    m_prev_vs = 1'b1;
    repeat (ncyc) begin
      push_exp(1'b1, 1'b1, 1'b0, 12'h000);
      @(posedge clk_i);
      #1;
    end
    arst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.due < cyc) check("stale", mon_e.due, 32'(cyc), 32'(mon_e.due));
      else check("out{hs,vs,de,rgb}", mon_e.due, 32'({hs_o, vs_o, de_o, rgb_o}),
                 32'({mon_e.hs, mon_e.vs, mon_e.de, mon_e.rgb}));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_i = 1'b1;
    sw_i   = 3'b100;
    hs_i   = 1'b1;
    vs_i   = 1'b1;
    de_i   = 1'b0;
    x_i    = '0;
    y_i    = '0;
    reset_pulse(3);

    // No frame boundary yet: black despite sw=100
    line(HA, 10);
    frame(3'b100, 2, 5, 1'b0);
    frame(3'b101, 1, 0, 1'b0);
    line(HA, 32);
    line(HA, 479);
    // Mid-frame select change is ignored until the next boundary
    frame(3'b101, 1, 200, 1'b0);
    sw_i = 3'b001;
    line(HA, 201);
    line(HA, 479);
    frame(3'b001, 1, 100, 1'b0);
    repeat (3) frame(3'b110, 1, 50, 1'b0);
    // Reset in the middle of a gradient line
    frame(3'b111, 1, 0, 1'b0);
    repeat (6) drive(1'b1, 1'b1, 1'b0, 0, 0);
    for (int x = 0; x < 300; x++) drive(1'b1, 1'b1, 1'b1, x, 0);
    reset_pulse(2);
    sw_i = 3'b111;
    line(HA, 0);
    frame(3'b111, 2, 0, 1'b0);
    frame(3'b111, 1, 0, 1'b0);

    repeat (14) begin
      sw_i = 3'($urandom_range(0, 7));
      frame(sw_i, 1, $urandom_range(0, 479), 1'b1);
      if ($urandom_range(0, 1) == 1) sw_i = 3'($urandom_range(0, 7));
      line(($urandom_range(0, 2) == 0) ? $urandom_range(1, HA - 1) : HA, $urandom_range(0, 479));
    end

    repeat (4) @(posedge clk_i);
    #1;
    check("drain", cyc, 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
